snax_simbacore_csr_arbiter: RTL



---
 rtl/snax_simbacore_csr_arb_pkg.sv | 17 +
 rtl/snax_simbacore_csr_id_fifo.sv | 53 +++++
 rtl/snax_simbacore_csr_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/snax_simbacore_csr_arb_pkg.sv
// Shared types and constants for the SimbaCore CSR request arbiter and its ID FIFO.
package snax_simbacore_csr_arb_pkg;

    localparam int unsigned CsrDataW = 32;

    typedef enum logic {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [CsrDataW-1:0] data;
        logic [CsrDataW-1:0] addr;
        logic                write;
    } csr_req_t;

endpackage

// File: rtl/snax_simbacore_csr_id_fifo.sv
// In-order FIFO holding the requester ID of every read still waiting for its response.
module snax_simbacore_csr_id_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == (PtrW+1)'(Depth));
    assign empty_o = (count == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr];

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
            if (do_push && !do_pop) begin
                count <= count + (PtrW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (PtrW+1)'(1);
            end
        end
    end

    // NOTE: storage has no reset; an entry is only read after being written, and count/pointers are reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/snax_simbacore_csr_arbiter.sv
// Round-robin arbiter sharing one SimbaCore CSR port among NumReq requesters, with in-order read routing.
// Define SNAX_SIMBACORE_CSR_ARB_PERF_EN to add the saturating stall counter output stall_cnt_o.
module snax_simbacore_csr_arbiter
    import snax_simbacore_csr_arb_pkg::*;
#(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumReq-1:0][CsrDataW-1:0]    req_data_i,
    input  logic [NumReq-1:0][CsrDataW-1:0]    req_addr_i,
    input  logic [NumReq-1:0]                  req_write_i,
    input  logic [NumReq-1:0]                  req_valid_i,
    output logic [NumReq-1:0]                  req_ready_o,
    output logic [NumReq-1:0][CsrDataW-1:0]    rsp_data_o,
    output logic [NumReq-1:0]                  rsp_valid_o,
    input  logic [NumReq-1:0]                  rsp_ready_i,
    output logic [CsrDataW-1:0]                csr_req_data_o,
    output logic [CsrDataW-1:0]                csr_req_addr_o,
    output logic                               csr_req_write_o,
    output logic                               csr_req_valid_o,
    input  logic                               csr_req_ready_i,
    input  logic [CsrDataW-1:0]                csr_rsp_data_i,
    input  logic                               csr_rsp_valid_i,
    output logic                               csr_rsp_ready_o
`ifdef SNAX_SIMBACORE_CSR_ARB_PERF_EN
    ,
    output logic [31:0]                        stall_cnt_o
`endif
);

    localparam int unsigned IdW = $clog2(NumReq);

    arb_state_e        state_q;
    logic [IdW-1:0]    lock_id_q;
    logic [IdW-1:0]    rr_ptr_q;
    logic [IdW-1:0]    rr_id;
    logic [IdW-1:0]    grant_id;
    logic [IdW-1:0]    next_ptr;
    logic [IdW-1:0]    fifo_head;
    logic [IdW-1:0]    head_id;
    logic [IdW:0]      idx;
    logic [NumReq-1:0] eligible;
    logic              rr_found;
    logic              handshake;
    logic              fifo_full;
    logic              fifo_empty;
    csr_req_t          winner;

    // NOTE: every always_comb assigns defaults first so no path can leave a latch behind.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            eligible[i] = req_valid_i[i] && (req_write_i[i] || !fifo_full);
        end
    end

    // Walk the requesters starting at the pointer; the sum stays below 2*NumReq, so one subtraction wraps it.
    always_comb begin
        rr_found = 1'b0;
        rr_id    = rr_ptr_q;
        idx      = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            idx = {1'b0, rr_ptr_q} + (IdW+1)'(k);
            if (idx >= (IdW+1)'(NumReq)) idx = idx - (IdW+1)'(NumReq);
            if (!rr_found && eligible[idx[IdW-1:0]]) begin
                rr_found = 1'b1;
                rr_id    = idx[IdW-1:0];
            end
        end
    end

    assign grant_id        = (state_q == LOCKED) ? lock_id_q : rr_id;
    assign csr_req_valid_o = (state_q == LOCKED) ? req_valid_i[lock_id_q] : rr_found;
    assign handshake       = csr_req_valid_o && csr_req_ready_i;
    assign next_ptr        = (grant_id == IdW'(NumReq - 1)) ? '0 : grant_id + IdW'(1);

    always_comb begin
        winner = '0;
        if (csr_req_valid_o) begin
            winner.data  = req_data_i[grant_id];
            winner.addr  = req_addr_i[grant_id];
            winner.write = req_write_i[grant_id];
        end
    end

    assign csr_req_data_o  = winner.data;
    assign csr_req_addr_o  = winner.addr;
    assign csr_req_write_o = winner.write;

    always_comb begin
        req_ready_o           = '0;
        req_ready_o[grant_id] = handshake;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= FREE;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            case (state_q)
                FREE: begin
                    if (csr_req_valid_o && !csr_req_ready_i) begin
                        state_q   <= LOCKED;
                        lock_id_q <= grant_id;
                    end
                end
                LOCKED: begin
                    if (csr_req_ready_i) state_q <= FREE;
                end
                default: state_q <= FREE;
            endcase
            if (handshake) rr_ptr_q <= next_ptr;
        end
    end

    snax_simbacore_csr_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdW)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake && !csr_req_write_o),
        .data_i  (grant_id),
        .pop_i   (csr_rsp_valid_i && csr_rsp_ready_o),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_id = fifo_empty ? '0 : fifo_head;

    // With nothing outstanding a stray response is accepted and dropped rather than wedging the manager.
    assign csr_rsp_ready_o = fifo_empty ? csr_rsp_valid_i : rsp_ready_i[head_id];
    assign rsp_data_o      = {NumReq{csr_rsp_data_i}};

    always_comb begin
        rsp_valid_o          = '0;
        rsp_valid_o[head_id] = csr_rsp_valid_i && !fifo_empty;
    end

`ifdef SNAX_SIMBACORE_CSR_ARB_PERF_EN
    logic stall;
    assign stall = |(req_valid_i & ~req_ready_o);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
        end else if (stall && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

    a_lock_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == LOCKED) |-> req_valid_i[lock_id_q]);

    a_rsp_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        csr_rsp_valid_i |-> !fifo_empty);

endmodule
